// File: rtl/uart_line_rx.sv
// rtl/uart_line_rx.sv - 16x oversampled UART receiver with end-of-line tagging and output FIFO
// Optional: define UART_LINE_RX_CR_STRIP_EN to silently discard received 0x0D bytes.
module uart_line_rx #(
   parameter int ClkFreqHz  = 20_000_000,
   parameter int BaudRate   = 115200,
   parameter int ParityEna  = 0,
   parameter int LineMaxLen = 80,
   parameter int FifoDepth  = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       eol_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       busy_o,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       overflow_o,
   output logic [6:0] line_cnt_o
);
   localparam int Div  = ClkFreqHz / (BaudRate * 16);
   localparam int DivW = (Div > 1) ? $clog2(Div) : 1;
   localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_PARITY    = 3'd3;
   localparam logic [2:0] S_STOP      = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;

   logic            sync1_q, rx_s;
   logic [2:0]      state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [3:0]      tick_cnt_q, tick_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_bad_q, par_bad_d;
   logic            perr_d, ferr_d, push_req, tick, is_cr;
   logic            ovf_q, perr_q, ferr_q;
   logic [6:0]      line_cnt_q, line_cnt_d;
   logic [8:0]      mem_q [FifoDepth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q, count_d;
   logic            full, pop, push_ok, eol_new;

   assign tick = (div_q == DivW'(Div - 1));

`ifdef UART_LINE_RX_CR_STRIP_EN
   assign is_cr = (shift_q == 8'h0D);
`else
   assign is_cr = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      div_d      = tick ? '0 : div_q + DivW'(1);
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_bad_d  = par_bad_q;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      push_req   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               // Re-phase the oversample clock to the falling edge of the start bit
               state_d    = S_START;
               div_d      = '0;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               par_bad_d  = 1'b0;
            end
         end
         S_START: begin
            if (tick) begin
               if (tick_cnt_q == 4'd7) begin
                  tick_cnt_d = '0;
                  state_d    = rx_s ? S_IDLE : S_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == 4'd15) begin
                  shift_d   = {rx_s, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_d = (ParityEna != 0) ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == 4'd15) begin
                  if (rx_s != ^shift_q) begin
                     perr_d    = 1'b1;
                     par_bad_d = 1'b1;
                  end
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == 4'd15) begin
                  if (rx_s) begin
                     push_req = !par_bad_q && !is_cr;
                     state_d  = S_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = S_WAIT_IDLE;
                  end
               end
            end
         end
         S_WAIT_IDLE: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign valid_o = (count_q != '0);
   assign full    = (count_q == (PtrW + 1)'(FifoDepth));
   assign pop     = valid_o && ready_i;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign push_ok = push_req && (!full || pop);
   assign eol_new = (shift_q == 8'h0A) || (line_cnt_q == 7'(LineMaxLen - 1));

   always_comb begin
      line_cnt_d = line_cnt_q;
      if (push_ok) line_cnt_d = eol_new ? '0 : line_cnt_q + 7'd1;
      count_d = count_q;
      if (push_ok && !pop) count_d = count_q + (PtrW + 1)'(1);
      else if (!push_ok && pop) count_d = count_q - (PtrW + 1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q    <= 1'b1;
         rx_s       <= 1'b1;
         state_q    <= S_IDLE;
         div_q      <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_bad_q  <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovf_q      <= 1'b0;
         line_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         sync1_q    <= rx_i;
         rx_s       <= sync1_q;
         state_q    <= state_d;
         div_q      <= div_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_bad_q  <= par_bad_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovf_q      <= ovf_q || (push_req && !push_ok);
         line_cnt_q <= line_cnt_d;
         count_q    <= count_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= {eol_new, shift_q};
   end

   assign byte_o       = valid_o ? mem_q[rd_ptr_q][7:0] : 8'h00;
   assign eol_o        = valid_o ? mem_q[rd_ptr_q][8] : 1'b0;
   assign busy_o       = (state_q != S_IDLE);
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign overflow_o   = ovf_q;
   assign line_cnt_o   = line_cnt_q;
endmodule

// File: tb/tb_uart_line_rx.sv
// tb/tb_uart_line_rx.sv - randomized bench for uart_line_rx against a queue-based line model
// Instance a runs fast (divisor 2), instance b runs default timing with even parity.
`timescale 1ns/1ps
module tb_uart_line_rx;
   localparam int BIT_A = 32;
   localparam int BIT_B = 160;
   localparam int LMAX  = 80;
   localparam int DEPTH = 16;
`ifdef UART_LINE_RX_CR_STRIP_EN
   localparam bit STRIP = 1'b1;
`else
   localparam bit STRIP = 1'b0;
`endif

   logic clk = 1'b0;
   always #25 clk = ~clk;

   logic       rst_n, rx_a, rx_b, rdy_b;
   logic       rdy_a = 1'b1;
   logic [7:0] byte_a, byte_b;
   logic       eol_a, eol_b, valid_a, valid_b, busy_a, busy_b;
   logic       perr_a, perr_b, ferr_a, ferr_b, ovf_a, ovf_b;
   logic [6:0] lcnt_a, lcnt_b;

   uart_line_rx #(.BaudRate(625_000)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .byte_o(byte_a), .eol_o(eol_a),
      .valid_o(valid_a), .ready_i(rdy_a), .busy_o(busy_a), .parity_err_o(perr_a),
      .frame_err_o(ferr_a), .overflow_o(ovf_a), .line_cnt_o(lcnt_a));

   uart_line_rx #(.ParityEna(1)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .byte_o(byte_b), .eol_o(eol_b),
      .valid_o(valid_b), .ready_i(rdy_b), .busy_o(busy_b), .parity_err_o(perr_b),
      .frame_err_o(ferr_b), .overflow_o(ovf_b), .line_cnt_o(lcnt_b));

   int n_vec = 0, n_err = 0;
   logic [8:0] exp_q_a[$], exp_q_b[$];
   int lc[2], ferr_exp[2], perr_exp[2], ferr_cnt[2], perr_cnt[2];
   bit ovf_exp[2];
   int rdy_mode_a = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: what the consumer should eventually see for one transmitted frame
   task automatic model_frame(input int w, input logic [7:0] b, input logic pe, input logic pb, input logic sb);
      logic eol;
      int   qs;
      if (!sb) ferr_exp[w]++;
      if (pe && (pb != ^b)) perr_exp[w]++;
      else if (sb && !(STRIP && b == 8'h0D)) begin
         qs = (w == 0) ? exp_q_a.size() : exp_q_b.size();
         if (qs >= DEPTH) ovf_exp[w] = 1'b1;
         else begin
            eol   = (b == 8'h0A) || (lc[w] + 1 == LMAX);
            lc[w] = eol ? 0 : lc[w] + 1;
            if (w == 0) exp_q_a.push_back({eol, b});
            else        exp_q_b.push_back({eol, b});
         end
      end
   endtask

   task automatic set_rx(input int w, input logic v, input int clks);
      if (w == 0) rx_a = v;
      else        rx_b = v;
      repeat (clks) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int w, input logic [7:0] b, input logic pe, input logic pb, input logic sb);
      int bt;
      bt = (w == 0) ? BIT_A : BIT_B;
      model_frame(w, b, pe, pb, sb);
      set_rx(w, 1'b0, bt);
      for (int i = 0; i < 8; i++) set_rx(w, b[i], bt);
      if (pe) set_rx(w, pb, bt);
      set_rx(w, sb, bt);
      if (!sb) begin
         set_rx(w, 1'b0, 2 * bt);
         set_rx(w, 1'b1, 2 * bt);
      end
   endtask

   task automatic settle(input int w, input bit expect_drained);
      repeat (24) @(posedge clk);
      @(negedge clk);
      if (w == 0) begin
         if (expect_drained) check("a_queue_drained", exp_q_a.size(), 0);
         check("a_line_cnt", lcnt_a, lc[0]);
         check("a_overflow", ovf_a, ovf_exp[0]);
         check("a_frame_err_pulses", ferr_cnt[0], ferr_exp[0]);
         check("a_parity_err_pulses", perr_cnt[0], 0);
         check("a_busy_idle", busy_a, 0);
      end else begin
         if (expect_drained) check("b_queue_drained", exp_q_b.size(), 0);
         check("b_line_cnt", lcnt_b, lc[1]);
         check("b_frame_err_pulses", ferr_cnt[1], ferr_exp[1]);
         check("b_parity_err_pulses", perr_cnt[1], perr_exp[1]);
         check("b_busy_idle", busy_b, 0);
      end
   endtask

   always @(posedge clk) begin
      #1;
      rdy_a = (rdy_mode_a == 0) ? 1'b1 : (rdy_mode_a == 1) ? 1'b0 : 1'($urandom_range(1, 0));
   end

   logic       hold_a = 1'b0;
   logic [8:0] held_a = '0;
   always @(negedge clk) begin
      if (ferr_a) ferr_cnt[0]++;
      if (perr_a) perr_cnt[0]++;
      if (ferr_b) ferr_cnt[1]++;
      if (perr_b) perr_cnt[1]++;
      if (rst_n) begin
         if (hold_a && valid_a) check("a_head_stable", {eol_a, byte_a}, held_a);
         hold_a = valid_a && !rdy_a;
         held_a = {eol_a, byte_a};
         if (valid_a && rdy_a) begin
            if (exp_q_a.size() == 0) check("a_pop_model_empty", exp_q_a.size(), 1);
            else check("a_pop_data", {eol_a, byte_a}, exp_q_a.pop_front());
         end
         if (valid_b && rdy_b) begin
            if (exp_q_b.size() == 0) check("b_pop_model_empty", exp_q_b.size(), 1);
            else check("b_pop_data", {eol_b, byte_b}, exp_q_b.pop_front());
         end
      end else begin
         hold_a = 1'b0;
      end
   end

   initial begin
      logic [7:0] b;
      rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_b = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_byte", byte_a, 0);
      check("rst_eol", eol_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_perr", perr_a, 0);
      check("rst_ferr", ferr_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_lcnt", lcnt_a, 0);
      check("rst_b_valid", valid_b, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Reset in the middle of a frame abandons it silently
      set_rx(0, 1'b0, BIT_A);
      set_rx(0, 1'b1, BIT_A / 2);
      @(negedge clk);
      check("midframe_busy", busy_a, 1);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4 * BIT_A) @(posedge clk);
      @(negedge clk);
      check("midframe_busy_after", busy_a, 0);
      check("midframe_valid_after", valid_a, 0);
      check("midframe_ferr", ferr_cnt[0], 0);
      @(posedge clk); #1;

      send_frame(0, 8'h48, 0, 0, 1);
      send_frame(0, 8'h69, 0, 0, 1);
      send_frame(0, 8'h0A, 0, 0, 1);
      settle(0, 1);

      for (int i = 0; i < 85; i++) send_frame(0, 8'h41, 0, 0, 1);
      settle(0, 1);
      send_frame(0, 8'h0A, 0, 0, 1);
      settle(0, 1);

      rdy_mode_a = 1;
      repeat (3) @(posedge clk); #1;
      for (int i = 0; i < 17; i++) send_frame(0, 8'($urandom_range(255, 0)), 0, 0, 1);
      settle(0, 0);
      check("ovf_fifo_full_valid", valid_a, 1);
      rdy_mode_a = 0;
      repeat (40) @(posedge clk); #1;
      settle(0, 1);

      send_frame(0, 8'h55, 0, 0, 0);
      settle(0, 1);
      send_frame(0, 8'h33, 0, 0, 1);
      settle(0, 1);

      rdy_mode_a = 2;
      for (int i = 0; i < 20; i++) begin
         b = ($urandom_range(3, 0) == 0) ? 8'h0A : 8'($urandom_range(255, 0));
         send_frame(0, b, 0, 0, ($urandom_range(9, 0) != 0));
      end
      rdy_mode_a = 0;
      settle(0, 1);

      send_frame(0, 8'h41, 0, 0, 1);
      send_frame(0, 8'h0D, 0, 0, 1);
      send_frame(0, 8'h0A, 0, 0, 1);
      settle(0, 1);

      send_frame(1, 8'h07, 1, 0, 1);
      settle(1, 1);
      send_frame(1, 8'h07, 1, 1, 1);
      settle(1, 1);

      // An 80-clock low pulse is half a bit: START samples it high again
      rx_b = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_mid", busy_b, 1);
      repeat (40) @(posedge clk);
      #1 rx_b = 1'b1;
      repeat (200) @(posedge clk);
      @(negedge clk);
      check("glitch_valid", valid_b, 0);
      settle(1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
